mips_lsu: RTL and testbench
===========================

# mips_lsu

Parametrised, handshaked load/store unit for the multi-cycle MIPS core. It replaces single-cycle combinational memory access with a request/response engine. It takes one decoded MIPS load/store (opcode, base, offset, rt) and drives a memory port that may stall and respond with variable latency. It returns the register writeback (or an error code) over a valid/ready channel. It supports all 12 core load/store opcodes, adds optional alignment checking and a response timeout, and generalises the address width.

## Interface
- ADDR_WIDTH, 32: effective/physical address width (>=3).
- ALIGN_CHECK, 1: 1 = misaligned lh/lhu/sh/lw/sw reports an error; 0 = low address bits ignored, as in the legacy datapath.
- TIMEOUT, 64: max cycles waiting for mem_rsp_valid; 0 disables the timeout.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, accepts the request.
- req_op  in  6  MIPS opcode[5:0].
- req_base  in  ADDR_WIDTH  GPR[rs].
- req_offset  in  16  imm, sign-extended internally.
- req_rt  in  32  GPR[rt]: store data, or merge value for lwl/lwr.
- req_dest  in  5  rt index for writeback.
- Address  out  ADDR_WIDTH  word-aligned address {eff[ADDR_WIDTH-1:2],2'b00}.
- MemRead / MemWrite  out  1  memory command, held until mem_req_ready.
- Write_data  out  32  store data (byte lanes positioned).
- Write_strb  out  4  byte enables.
- mem_req_ready  in  1  command accepted this cycle.
- Read_data  in  32  load word, valid with mem_rsp_valid.
- mem_rsp_valid  in  1  read data / write acknowledge.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_wen  out  1  1 for a successful load.
- rsp_waddr  out  5  latched req_dest.
- rsp_wdata  out  32  load result.
- rsp_err  out  2  00 ok, 01 misaligned, 10 illegal opcode, 11 timeout.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. req_ready = (state==IDLE).
- IDLE: on req_valid, latch op/eff/rt/dest, where eff = req_base + sext(req_offset) mod 2^ADDR_WIDTH.
  - Illegal or misaligned request: go to RESP with the matching err; no memory command.
  - Otherwise go to ISSUE.
- Legal ops:
  - Loads 100000 lb, 100001 lh, 100010 lwl, 100011 lw, 100100 lbu, 100101 lhu, 100110 lwr.
  - Stores 101000 sb, 101001 sh, 101010 swl, 101011 sw, 101110 swr.
- ISSUE: assert MemRead (load) or MemWrite (store). Go to WAIT on mem_req_ready, clearing the timeout counter.
- WAIT: commands deasserted; the counter increments each cycle.
  - mem_rsp_valid: capture the merged load result, then go to RESP with err 00.
  - Counter reaches TIMEOUT (TIMEOUT!=0) with no response: go to RESP with err 11, rsp_wen=0.
- RESP: rsp_valid=1 and outputs held stable. On rsp_ready, return to IDLE.
- Load result, with a = eff[1:0]:
  - lb/lbu: byte a, sign- or zero-extended. lh/lhu: half a[1], sign- or zero-extended. lw: Read_data.
  - lwl a=0..3: {R[7:0],rt[23:0]}, {R[15:0],rt[15:0]}, {R[23:0],rt[7:0]}, R.
  - lwr a=0..3: R, {rt[31:24],R[31:8]}, {rt[31:16],R[31:16]}, {rt[31:8],R[31:24]}.
- Stores:
  - sb: strb one-hot at a, data {4{rt[7:0]}}. sh: strb a[1]?1100:0011, data {2{rt[15:0]}}. sw: 1111, data rt.
  - swl: strb a=0..3: 0001, 0011, 0111, 1111; data rt>>(8*(3-a)).
  - swr: strb 1111, 1110, 1100, 1000; data rt<<(8*a).
- Stores complete on mem_rsp_valid with rsp_wen=0, rsp_wdata=0.
- Errors always give rsp_wen=0, rsp_wdata=0.

## Timing
- Reset (rst=0 at an edge): state IDLE, req_ready=1, and every other output (MemRead, MemWrite, rsp_valid, rsp_wen, rsp_err, Address, Write_data, Write_strb, rsp_waddr, rsp_wdata) is 0.
- Reset mid-transaction aborts the transaction; the in-flight memory response is ignored.
- Best case: request accepted at edge 0, ISSUE in cycle 1 (mem_req_ready=1), response in cycle 2, rsp_valid in cycle 3. Error requests: rsp_valid in cycle 1.
- mem_rsp_valid outside WAIT (e.g. late, after a timeout) is ignored.
- With TIMEOUT=N, err 11 appears when no response arrives within N WAIT cycles; a response in WAIT cycle N still wins.
- rsp_valid held until rsp_ready; no new request is accepted until the edge after the handshake.

## Test plan
- lb, base 0x1000, offset 0xFFFF, Read_data 0x80123456 -> Address 0x0FFC, rsp_wdata 0xFFFFFF80, rsp_wen=1, rsp_waddr=req_dest.
- lwr at eff 0x2001, rt 0xAABBCCDD, Read_data 0x11223344 -> rsp_wdata 0xAA112233. swl at eff 0x2001, rt 0xAABBCCDD -> Write_strb 0011, Write_data[15:0] 0xAABB.
- lw at eff 0x3002 with ALIGN_CHECK=1 -> no MemRead, rsp_valid in cycle 1, rsp_err 01. Opcode 0x2F -> rsp_err 10.
- TIMEOUT=4, mem_rsp_valid never asserted -> rsp_err 11 after 4 WAIT cycles. A late mem_rsp_valid in RESP changes nothing.
- mem_req_ready low 3 cycles, rsp_ready low 2 cycles -> MemWrite and Address stable throughout; rsp outputs stable; req_ready returns to 1 one cycle after the handshake.
- rst=0 during WAIT -> next cycle IDLE, all outputs 0; the following request completes normally.

Source files
------------

// File: rtl/mips_lsu.sv
// -----------------------------------------------------------------------------
// mips_lsu : handshaked load/store unit for the multi-cycle MIPS core.
//
// Accepts one decoded load/store (opcode, base, offset, rt, dest), drives a
// stallable memory command port, waits a variable number of cycles for the
// memory response and returns the register writeback (or an error code) on a
// valid/ready response channel.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-low reset
//   req_valid / req_ready     request handshake; ready only while idle
//   req_op, req_base,         opcode[5:0], GPR[rs], 16-bit immediate,
//   req_offset, req_rt,       GPR[rt] (store data / lwl-lwr merge value),
//   req_dest                  writeback register index
//   Address                   word-aligned effective address
//   MemRead / MemWrite        memory command, held until mem_req_ready
//   Write_data / Write_strb   lane-positioned store data and byte enables
//   mem_req_ready             command accepted this cycle
//   Read_data, mem_rsp_valid  read data / write acknowledge
//   rsp_valid / rsp_ready     response handshake
//   rsp_wen, rsp_waddr,       writeback enable, register index, load data,
//   rsp_wdata, rsp_err        error code (00 ok, 01 misaligned, 10 illegal,
//                             11 timeout)
// -----------------------------------------------------------------------------
module mips_lsu #(
   parameter int ADDR_WIDTH  = 32,
   parameter bit ALIGN_CHECK = 1'b1,
   parameter int TIMEOUT     = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [5:0]            req_op,
   input  logic [ADDR_WIDTH-1:0] req_base,
   input  logic [15:0]           req_offset,
   input  logic [31:0]           req_rt,
   input  logic [4:0]            req_dest,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic [31:0]           Write_data,
   output logic [3:0]            Write_strb,
   input  logic                  mem_req_ready,
   input  logic [31:0]           Read_data,
   input  logic                  mem_rsp_valid,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_wen,
   output logic [4:0]            rsp_waddr,
   output logic [31:0]           rsp_wdata,
   output logic [1:0]            rsp_err
);

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LWL = 6'b100010;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LWR = 6'b100110;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SWL = 6'b101010;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SWR = 6'b101110;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_ALIGN = 2'b01;
   localparam logic [1:0] ERR_ILL   = 2'b10;
   localparam logic [1:0] ERR_TMO   = 2'b11;

   // The counter only needs to hold 0..TIMEOUT-1: the last WAIT cycle is the
   // one where it equals TIMEOUT-1.
   localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Opcode helpers
   // ---------------------------------------------------------------------------
   function automatic logic is_load_op(input logic [5:0] op);
      return op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR};
   endfunction

   function automatic logic is_store_op(input logic [5:0] op);
      return op inside {OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR};
   endfunction

   // Only halfword and full-word accesses have alignment constraints; the
   // unaligned-word opcodes (lwl/lwr/swl/swr) exist precisely to be misaligned.
   function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] a);
      logic mis;
      mis = 1'b0;
      case (op)
         OP_LH, OP_LHU, OP_SH: mis = a[0];
         OP_LW, OP_SW:         mis = |a;
         default:              mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Store lane placement: returns {strobe[3:0], data[31:0]}.
   function automatic logic [35:0] store_lanes(input logic [5:0]  op,
                                               input logic [1:0]  a,
                                               input logic [31:0] rt);
      logic [3:0]  strb;
      logic [31:0] data;
      strb = 4'b0000;
      data = 32'h0;
      case (op)
         OP_SB: begin
            strb = 4'b0001 << a;
            data = {4{rt[7:0]}};
         end
         OP_SH: begin
            strb = a[1] ? 4'b1100 : 4'b0011;
            data = {2{rt[15:0]}};
         end
         OP_SW: begin
            strb = 4'b1111;
            data = rt;
         end
         OP_SWL: begin
            case (a)
               2'd0:    begin strb = 4'b0001; data = {24'h0, rt[31:24]}; end
               2'd1:    begin strb = 4'b0011; data = {16'h0, rt[31:16]}; end
               2'd2:    begin strb = 4'b0111; data = {8'h0,  rt[31:8]};  end
               default: begin strb = 4'b1111; data = rt;                 end
            endcase
         end
         OP_SWR: begin
            case (a)
               2'd0:    begin strb = 4'b1111; data = rt;                 end
               2'd1:    begin strb = 4'b1110; data = {rt[23:0], 8'h0};  end
               2'd2:    begin strb = 4'b1100; data = {rt[15:0], 16'h0}; end
               default: begin strb = 4'b1000; data = {rt[7:0],  24'h0}; end
            endcase
         end
         default: begin
            strb = 4'b0000;
            data = 32'h0;
         end
      endcase
      return {strb, data};
   endfunction

   // Load result extraction and lwl/lwr merge with the old rt value.
   function automatic logic [31:0] load_merge(input logic [5:0]  op,
                                              input logic [1:0]  a,
                                              input logic [31:0] rt,
                                              input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (a)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h   = a[1] ? rd[31:16] : rd[15:0];
      res = 32'h0;
      case (op)
         OP_LB:  res = {{24{b[7]}}, b};
         OP_LBU: res = {24'h0, b};
         OP_LH:  res = {{16{h[15]}}, h};
         OP_LHU: res = {16'h0, h};
         OP_LW:  res = rd;
         OP_LWL: begin
            case (a)
               2'd0:    res = {rd[7:0],  rt[23:0]};
               2'd1:    res = {rd[15:0], rt[15:0]};
               2'd2:    res = {rd[23:0], rt[7:0]};
               default: res = rd;
            endcase
         end
         OP_LWR: begin
            case (a)
               2'd0:    res = rd;
               2'd1:    res = {rt[31:24], rd[31:8]};
               2'd2:    res = {rt[31:16], rd[31:16]};
               default: res = {rt[31:8],  rd[31:24]};
            endcase
         end
         default: res = 32'h0;
      endcase
      return res;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t                  state_q, state_d;
   logic [5:0]              op_q, op_d;
   logic [ADDR_WIDTH-1:0]   eff_q, eff_d;
   logic [31:0]             rt_q, rt_d;
   logic [4:0]              dest_q, dest_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [3:0]              strb_q, strb_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    wen_q, wen_d;
   logic [31:0]             res_q, res_d;
   logic [1:0]              err_q, err_d;

   // Effective address of the incoming request; the offset is sign-extended
   // wide enough to cover any ADDR_WIDTH before truncation.
   logic [ADDR_WIDTH+15:0]  off_ext;
   logic [ADDR_WIDTH-1:0]   eff_in;
   logic [35:0]             lanes_in;

   assign off_ext  = {{ADDR_WIDTH{req_offset[15]}}, req_offset};
   assign eff_in   = req_base + off_ext[ADDR_WIDTH-1:0];
   assign lanes_in = store_lanes(req_op, eff_in[1:0], req_rt);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      eff_d   = eff_q;
      rt_d    = rt_q;
      dest_d  = dest_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      cnt_d   = cnt_q;
      wen_d   = wen_q;
      res_d   = res_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               eff_d   = eff_in;
               rt_d    = req_rt;
               dest_d  = req_dest;
               wen_d   = 1'b0;
               res_d   = 32'h0;
               cnt_d   = '0;
               wdata_d = 32'h0;
               strb_d  = 4'b0000;
               if (!(is_load_op(req_op) || is_store_op(req_op))) begin
                  err_d   = ERR_ILL;
                  state_d = S_RESP;
               end else if (ALIGN_CHECK && is_misaligned(req_op, eff_in[1:0])) begin
                  err_d   = ERR_ALIGN;
                  state_d = S_RESP;
               end else begin
                  err_d   = ERR_OK;
                  state_d = S_ISSUE;
                  if (is_store_op(req_op)) begin
                     strb_d  = lanes_in[35:32];
                     wdata_d = lanes_in[31:0];
                  end
               end
            end
         end

         S_ISSUE: begin
            if (mem_req_ready) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            // A response arriving in the final counted cycle beats the timeout.
            if (mem_rsp_valid) begin
               err_d   = ERR_OK;
               state_d = S_RESP;
               if (is_load_op(op_q)) begin
                  wen_d = 1'b1;
                  res_d = load_merge(op_q, eff_q[1:0], rt_q, Read_data);
               end else begin
                  wen_d = 1'b0;
                  res_d = 32'h0;
               end
            end else if (TIMEOUT != 0) begin
               if (cnt_q == CNT_LAST) begin
                  err_d   = ERR_TMO;
                  wen_d   = 1'b0;
                  res_d   = 32'h0;
                  state_d = S_RESP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
               wen_d   = 1'b0;
               res_d   = 32'h0;
               err_d   = ERR_OK;
               wdata_d = 32'h0;
               strb_d  = 4'b0000;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         op_q    <= 6'h0;
         eff_q   <= '0;
         rt_q    <= 32'h0;
         dest_q  <= 5'h0;
         wdata_q <= 32'h0;
         strb_q  <= 4'h0;
         cnt_q   <= '0;
         wen_q   <= 1'b0;
         res_q   <= 32'h0;
         err_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         eff_q   <= eff_d;
         rt_q    <= rt_d;
         dest_q  <= dest_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         cnt_q   <= cnt_d;
         wen_q   <= wen_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign req_ready  = (state_q == S_IDLE);
   assign MemRead    = (state_q == S_ISSUE) && is_load_op(op_q);
   assign MemWrite   = (state_q == S_ISSUE) && is_store_op(op_q);
   assign Address    = {eff_q[ADDR_WIDTH-1:2], 2'b00};
   assign Write_data = wdata_q;
   assign Write_strb = strb_q;
   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_wen    = wen_q;
   assign rsp_waddr  = dest_q;
   assign rsp_wdata  = res_q;
   assign rsp_err    = err_q;

endmodule

// File: tb/tb_mips_lsu.sv
// -----------------------------------------------------------------------------
// tb_mips_lsu : self-checking bench for mips_lsu (ADDR_WIDTH=32, ALIGN_CHECK=1,
// TIMEOUT=4). Directed scenarios plus randomized transactions compared with a
// byte/shift-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mips_lsu;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_op;
   logic [31:0] req_base;
   logic [15:0] req_offset;
   logic [31:0] req_rt;
   logic [4:0]  req_dest;
   logic [31:0] Address;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Write_data;
   logic [3:0]  Write_strb;
   logic        mem_req_ready;
   logic [31:0] Read_data;
   logic        mem_rsp_valid;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_wen;
   logic [4:0]  rsp_waddr;
   logic [31:0] rsp_wdata;
   logic [1:0]  rsp_err;

   int errors = 0;
   int checks = 0;

   mips_lsu #(.ADDR_WIDTH(32), .ALIGN_CHECK(1'b1), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_base(req_base), .req_offset(req_offset), .req_rt(req_rt),
      .req_dest(req_dest),
      .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite),
      .Write_data(Write_data), .Write_strb(Write_strb),
      .mem_req_ready(mem_req_ready), .Read_data(Read_data),
      .mem_rsp_valid(mem_rsp_valid),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wen(rsp_wen),
      .rsp_waddr(rsp_waddr), .rsp_wdata(rsp_wdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   // Observations of the last transaction
   int          obs_lat;
   bit          obs_cmd, obs_rd, obs_wr, obs_cmd_stable, obs_rsp_stable;
   bit          obs_ready_acc, obs_ready_after, obs_valid_after;
   logic [31:0] obs_addr, obs_wd, obs_wdata;
   logic [3:0]  obs_strb;
   logic        obs_wen;
   logic [4:0]  obs_waddr;
   logic [1:0]  obs_err;

   // ---------------------------------------------------------------------------
   // Reference model: straight from the ISA rules using byte arithmetic.
   // ---------------------------------------------------------------------------
   task automatic model(input logic [5:0] op, input logic [31:0] eff,
                        input logic [31:0] rt, input logic [31:0] rd,
                        output logic [1:0] err, output bit is_ld, output bit is_st,
                        output logic [31:0] wdata, output logic [3:0] strb,
                        output logic [31:0] sdata);
      int unsigned a, size, v;
      longint unsigned m;
      a     = eff % 4;
      is_ld = (op >= 6'h20 && op <= 6'h26);
      is_st = (op == 6'h28 || op == 6'h29 || op == 6'h2A || op == 6'h2B || op == 6'h2E);
      size  = (op == 6'h21 || op == 6'h25 || op == 6'h29) ? 2 :
              (op == 6'h23 || op == 6'h2B) ? 4 : 1;
      wdata = 32'h0;
      strb  = 4'h0;
      sdata = 32'h0;
      if (!is_ld && !is_st) begin err = 2'b10; is_ld = 0; return; end
      if (eff % size != 0) begin err = 2'b01; is_ld = 0; is_st = 0; return; end
      err = 2'b00;
      case (op)
         6'h20: begin v = (rd >> (8*a)) & 8'hFF; wdata = (v >= 128) ? (v | 32'hFFFFFF00) : v; end
         6'h24: wdata = (rd >> (8*a)) & 8'hFF;
         6'h21: begin v = (rd >> (16*(a/2))) & 16'hFFFF; wdata = (v >= 32768) ? (v | 32'hFFFF0000) : v; end
         6'h25: wdata = (rd >> (16*(a/2))) & 16'hFFFF;
         6'h23: wdata = rd;
         6'h22: begin
            m = (64'd1 << (8*(3-a))) - 1;
            wdata = 32'((64'(rd) << (8*(3-a))) | (64'(rt) & m));
         end
         6'h26: wdata = (rd >> (8*a)) | (rt & ~(32'hFFFFFFFF >> (8*a)));
         6'h28: begin strb = 4'(1 << a); sdata = (rt & 32'hFF) * 32'h01010101; end
         6'h29: begin strb = 4'(3 << (2*(a/2))); sdata = (rt & 32'hFFFF) * 32'h00010001; end
         6'h2B: begin strb = 4'hF; sdata = rt; end
         6'h2A: begin strb = 4'((1 << (a+1)) - 1); sdata = rt >> (8*(3-a)); end
         6'h2E: begin strb = 4'((15 << a) & 15); sdata = rt << (8*a); end
         default: ;
      endcase
   endtask

   // ---------------------------------------------------------------------------
   // Transaction driver: plays the memory (grant after gnt ISSUE cycles, answer
   // after rsp WAIT cycles, rsp<0 = never) and the consumer (ack cycles stall).
   // ---------------------------------------------------------------------------
   task automatic run_txn(input logic [5:0] op, input logic [31:0] base,
                          input logic [15:0] off, input logic [31:0] rt,
                          input logic [4:0] dest, input logic [31:0] rdata,
                          input int gnt, input int rsp, input int ack, input bit late);
      int cyc, issue_n, wait_n;
      bit granted;
      @(negedge clk);
      obs_ready_acc = req_ready;
      req_valid = 1'b1; req_op = op; req_base = base; req_offset = off;
      req_rt = rt; req_dest = dest;
      @(negedge clk);
      req_valid = 1'b0; req_op = 6'($urandom); req_base = $urandom;
      req_offset = 16'($urandom); req_rt = $urandom; req_dest = 5'($urandom);
      obs_cmd = 0; obs_rd = 0; obs_wr = 0; obs_cmd_stable = 1; obs_rsp_stable = 1;
      obs_addr = 0; obs_wd = 0; obs_strb = 0;
      cyc = 1; issue_n = 0; wait_n = 0; granted = 0;
      while (!rsp_valid && cyc < 40) begin
         mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; Read_data = $urandom;
         if (MemRead || MemWrite) begin
            if (!obs_cmd) begin
               obs_cmd = 1; obs_rd = MemRead; obs_wr = MemWrite;
               obs_addr = Address; obs_wd = Write_data; obs_strb = Write_strb;
            end else if (granted || obs_rd != MemRead || obs_wr != MemWrite ||
                         obs_addr != Address || obs_wd != Write_data ||
                         obs_strb != Write_strb) begin
               obs_cmd_stable = 0;
            end
            if (issue_n == gnt) begin mem_req_ready = 1'b1; granted = 1; end
            issue_n++;
         end else if (granted) begin
            if (wait_n == rsp) begin mem_rsp_valid = 1'b1; Read_data = rdata; end
            wait_n++;
         end
         @(negedge clk);
         cyc++;
      end
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      obs_lat = rsp_valid ? cyc : -1;
      obs_wen = rsp_wen; obs_waddr = rsp_waddr; obs_wdata = rsp_wdata; obs_err = rsp_err;
      for (int k = 0; k < ack; k++) begin
         if (late) begin mem_rsp_valid = 1'b1; Read_data = ~rdata; end
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         if (rsp_valid !== 1'b1 || rsp_wen !== obs_wen || rsp_waddr !== obs_waddr ||
             rsp_wdata !== obs_wdata || rsp_err !== obs_err)
            obs_rsp_stable = 0;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      obs_ready_after = req_ready;
      obs_valid_after = rsp_valid;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      logic [110:0] v;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      v = {MemRead, MemWrite, rsp_valid, rsp_wen, rsp_err, Address, Write_data,
           Write_strb, rsp_waddr, rsp_wdata};
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
      checks++;
      if (v !== '0) begin errors++; $display("FAIL reset_outputs got=%h want=0", v); end
      rst = 1'b1;
      $display("txn reset: req_ready=%b outputs=%h", req_ready, v);
   endtask

   task automatic test_lb();
      run_txn(6'h20, 32'h1000, 16'hFFFF, 32'h0, 5'd7, 32'h80123456, 0, 0, 0, 0);
      $display("txn lb: addr=%h wdata=%h wen=%b lat=%0d", obs_addr, obs_wdata, obs_wen, obs_lat);
      checks++;
      if (obs_ready_acc !== 1'b1) begin errors++; $display("FAIL lb_ready got=%b want=1", obs_ready_acc); end
      checks++;
      if (!obs_rd || obs_addr !== 32'h0FFC) begin errors++; $display("FAIL lb_addr got=%h rd=%b want=00000ffc rd=1", obs_addr, obs_rd); end
      checks++;
      if (obs_wdata !== 32'hFFFFFF80 || obs_wen !== 1'b1 || obs_waddr !== 5'd7 || obs_err !== 2'b00)
         begin errors++; $display("FAIL lb_result got=%h/%b/%0d/%b want=ffffff80/1/7/00", obs_wdata, obs_wen, obs_waddr, obs_err); end
      checks++;
      if (obs_lat !== 3) begin errors++; $display("FAIL lb_latency got=%0d want=3", obs_lat); end
   endtask

   task automatic test_unaligned_word();
      run_txn(6'h26, 32'h2000, 16'h0001, 32'hAABBCCDD, 5'd3, 32'h11223344, 0, 1, 0, 0);
      $display("txn lwr: wdata=%h err=%b", obs_wdata, obs_err);
      checks++;
      if (obs_wdata !== 32'hAA112233 || obs_wen !== 1'b1 || obs_err !== 2'b00)
         begin errors++; $display("FAIL lwr_result got=%h/%b/%b want=aa112233/1/00", obs_wdata, obs_wen, obs_err); end
      run_txn(6'h2A, 32'h2000, 16'h0001, 32'hAABBCCDD, 5'd4, 32'h0, 1, 0, 0, 0);
      $display("txn swl: strb=%b wd=%h wen=%b", obs_strb, obs_wd, obs_wen);
      checks++;
      if (!obs_wr || obs_strb !== 4'b0011 || obs_wd[15:0] !== 16'hAABB || obs_addr !== 32'h2000)
         begin errors++; $display("FAIL swl_cmd got=%b/%h/%h want=0011/aabb/00002000", obs_strb, obs_wd[15:0], obs_addr); end
      checks++;
      if (obs_wen !== 1'b0 || obs_wdata !== 32'h0 || obs_err !== 2'b00 || obs_lat !== 4)
         begin errors++; $display("FAIL swl_rsp got=%b/%h/%b/%0d want=0/0/00/4", obs_wen, obs_wdata, obs_err, obs_lat); end
   endtask

   task automatic test_errors();
      run_txn(6'h23, 32'h3000, 16'h0002, 32'h0, 5'd9, 32'h0, 0, 0, 0, 0);
      $display("txn lw-misaligned: err=%b lat=%0d cmd=%b", obs_err, obs_lat, obs_cmd);
      checks++;
      if (obs_err !== 2'b01 || obs_lat !== 1 || obs_cmd || obs_wen !== 1'b0 || obs_wdata !== 32'h0)
         begin errors++; $display("FAIL misalign got=%b/%0d/%b/%b want=01/1/0/0", obs_err, obs_lat, obs_cmd, obs_wen); end
      run_txn(6'h2F, 32'h3000, 16'h0000, 32'h0, 5'd9, 32'h0, 0, 0, 0, 0);
      $display("txn illegal: err=%b lat=%0d cmd=%b", obs_err, obs_lat, obs_cmd);
      checks++;
      if (obs_err !== 2'b10 || obs_lat !== 1 || obs_cmd || obs_wen !== 1'b0)
         begin errors++; $display("FAIL illegal got=%b/%0d/%b/%b want=10/1/0/0", obs_err, obs_lat, obs_cmd, obs_wen); end
   endtask

   task automatic test_timeout();
      run_txn(6'h23, 32'h5000, 16'h0004, 32'h0, 5'd11, 32'h12345678, 0, -1, 2, 1);
      $display("txn timeout: err=%b lat=%0d stable=%b", obs_err, obs_lat, obs_rsp_stable);
      checks++;
      if (obs_err !== 2'b11 || obs_lat !== TMO + 2 || obs_wen !== 1'b0 || obs_wdata !== 32'h0)
         begin errors++; $display("FAIL timeout got=%b/%0d/%b want=11/%0d/0", obs_err, obs_lat, obs_wen, TMO + 2); end
      checks++;
      if (!obs_rsp_stable) begin errors++; $display("FAIL timeout_late_rsp got=changed want=stable"); end
      run_txn(6'h23, 32'h5000, 16'h0008, 32'h0, 5'd12, 32'h0BADF00D, 0, TMO - 1, 0, 0);
      $display("txn last-cycle rsp: err=%b wdata=%h lat=%0d", obs_err, obs_wdata, obs_lat);
      checks++;
      if (obs_err !== 2'b00 || obs_wdata !== 32'h0BADF00D || obs_lat !== TMO + 2)
         begin errors++; $display("FAIL last_cycle_rsp got=%b/%h/%0d want=00/0badf00d/%0d", obs_err, obs_wdata, obs_lat, TMO + 2); end
   endtask

   task automatic test_back_to_back_stall();
      run_txn(6'h29, 32'h4000, 16'h0002, 32'h9876ABCD, 5'd5, 32'h0, 3, 0, 2, 0);
      $display("txn sh-stall: strb=%b wd=%h lat=%0d stable=%b/%b ready=%b", obs_strb, obs_wd, obs_lat, obs_cmd_stable, obs_rsp_stable, obs_ready_after);
      checks++;
      if (!obs_wr || !obs_cmd_stable || obs_strb !== 4'b1100 || obs_wd !== 32'hABCDABCD || obs_addr !== 32'h4000)
         begin errors++; $display("FAIL stall_cmd got=%b/%b/%h/%h want=1/1100/abcdabcd/00004000", obs_cmd_stable, obs_strb, obs_wd, obs_addr); end
      checks++;
      if (obs_lat !== 6 || !obs_rsp_stable) begin errors++; $display("FAIL stall_rsp got=%0d/%b want=6/1", obs_lat, obs_rsp_stable); end
      checks++;
      if (obs_ready_after !== 1'b1 || obs_valid_after !== 1'b0)
         begin errors++; $display("FAIL stall_handshake got=%b/%b want=1/0", obs_ready_after, obs_valid_after); end
   endtask

   task automatic test_reset_mid();
      logic [110:0] v;
      @(negedge clk);
      req_valid = 1'b1; req_op = 6'h23; req_base = 32'h6000; req_offset = 16'h0;
      req_rt = 32'h0; req_dest = 5'd13;
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (MemRead !== 1'b1) begin errors++; $display("FAIL midrst_issue got=%b want=1", MemRead); end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst = 1'b0; mem_rsp_valid = 1'b1; Read_data = 32'hDEADBEEF;
      @(negedge clk);
      rst = 1'b1; mem_rsp_valid = 1'b0;
      v = {MemRead, MemWrite, rsp_valid, rsp_wen, rsp_err, Address, Write_data,
           Write_strb, rsp_waddr, rsp_wdata};
      $display("txn reset-mid: req_ready=%b outputs=%h", req_ready, v);
      checks++;
      if (req_ready !== 1'b1 || v !== '0) begin errors++; $display("FAIL midrst_idle got=%b/%h want=1/0", req_ready, v); end
      mem_rsp_valid = 1'b1;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL stray_rsp got=%b/%b want=0/1", rsp_valid, req_ready); end
      run_txn(6'h24, 32'h6000, 16'h0002, 32'h0, 5'd14, 32'hA1B2C3D4, 0, 0, 0, 0);
      $display("txn post-reset lbu: wdata=%h lat=%0d", obs_wdata, obs_lat);
      checks++;
      if (obs_wdata !== 32'h000000B2 || obs_wen !== 1'b1 || obs_waddr !== 5'd14 || obs_lat !== 3)
         begin errors++; $display("FAIL post_reset got=%h/%b/%0d/%0d want=000000b2/1/14/3", obs_wdata, obs_wen, obs_waddr, obs_lat); end
   endtask

   task automatic test_random();
      logic [5:0]  legal [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                  6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E};
      logic [5:0]  op;
      logic [31:0] base, rt, rd, eff, e_wdata, e_sdata;
      logic [15:0] off;
      logic [4:0]  dest;
      logic [1:0]  e_err;
      logic [3:0]  e_strb;
      bit          e_ld, e_st, late;
      int          gnt, rsp, ack, e_lat;
      for (int i = 0; i < 60; i++) begin
         op   = ($urandom_range(0, 15) == 0) ? 6'($urandom) : legal[$urandom_range(0, 11)];
         base = $urandom; off = 16'($urandom); rt = $urandom; rd = $urandom;
         dest = 5'($urandom);
         gnt  = $urandom_range(0, 2); rsp = $urandom_range(0, TMO - 1);
         ack  = $urandom_range(0, 2); late = 1'($urandom);
         eff  = base + {{16{off[15]}}, off};
         model(op, eff, rt, rd, e_err, e_ld, e_st, e_wdata, e_strb, e_sdata);
         e_lat = (e_err != 2'b00) ? 1 : gnt + rsp + 3;
         run_txn(op, base, off, rt, dest, rd, gnt, rsp, ack, late);
         $display("txn rnd%0d: op=%h eff=%h err=%b wen=%b wdata=%h strb=%b lat=%0d",
                  i, op, eff, obs_err, obs_wen, obs_wdata, obs_strb, obs_lat);
         checks++;
         if (obs_err !== e_err || obs_wen !== e_ld || obs_wdata !== e_wdata || obs_waddr !== dest)
            begin errors++; $display("FAIL rnd_rsp%0d got=%b/%b/%h/%0d want=%b/%b/%h/%0d", i, obs_err, obs_wen, obs_wdata, obs_waddr, e_err, e_ld, e_wdata, dest); end
         checks++;
         if (obs_lat !== e_lat || !obs_rsp_stable || obs_ready_after !== 1'b1)
            begin errors++; $display("FAIL rnd_timing%0d got=%0d/%b/%b want=%0d/1/1", i, obs_lat, obs_rsp_stable, obs_ready_after, e_lat); end
         checks++;
         if (obs_cmd !== (e_err == 2'b00) ||
             (obs_cmd && (obs_rd !== e_ld || obs_wr !== e_st || !obs_cmd_stable ||
                          obs_addr !== {eff[31:2], 2'b00})))
            begin errors++; $display("FAIL rnd_cmd%0d got=%b/%b/%b/%h want=%b/%b/%b/%h", i, obs_cmd, obs_rd, obs_wr, obs_addr, (e_err == 2'b00), e_ld, e_st, {eff[31:2], 2'b00}); end
         if (e_st) begin
            checks++;
            if (obs_strb !== e_strb || obs_wd !== e_sdata)
               begin errors++; $display("FAIL rnd_store%0d got=%b/%h want=%b/%h", i, obs_strb, obs_wd, e_strb, e_sdata); end
         end
      end
   endtask

   initial begin
      rst = 1'b0; req_valid = 1'b0; req_op = 6'h0; req_base = 32'h0; req_offset = 16'h0;
      req_rt = 32'h0; req_dest = 5'h0; mem_req_ready = 1'b0; Read_data = 32'h0;
      mem_rsp_valid = 1'b0; rsp_ready = 1'b0;
      test_reset();
      test_lb();
      test_unaligned_word();
      test_errors();
      test_timeout();
      test_back_to_back_stall();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
